// File: rtl/pga_pkg.sv
// PGA gain driver shared types: gain code, FSM states,
// SPI opcode and gain-to-PGA code lookup.
package pga_pkg;

  typedef logic [1:0] gain_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_SETTLE
  } state_t;

  localparam logic [7:0] PGA_WR_GAIN = 8'h41;

  function automatic logic [7:0] pga_code(input gain_t g);
    case (g)
      2'd0:    pga_code = 8'h00;
      2'd1:    pga_code = 8'h01;
      2'd2:    pga_code = 8'h03;
      default: pga_code = 8'h07;
    endcase
  endfunction

endpackage

// File: rtl/pga_spi_shifter.sv
// 16-bit SPI mode-0 serializer, MSB first, sclk half-period CLK_DIV.
// Ports: clk, rst, start/frame in; cs_n, sclk, mosi out; last_fall, done strobes.
module pga_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] frame,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic        last_fall,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic        shifting;
  logic        holding;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] sh;
  logic        tick;

  assign tick = (div_cnt == DIV_LAST);
  // Strobes for the top FSM, aligned with the edge they describe
  assign last_fall = shifting && tick && sclk && (bit_cnt == 4'd15);
  assign done      = holding && tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifting <= 1'b0;
      holding  <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      sh       <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else if (start) begin
      shifting <= 1'b1;
      holding  <= 1'b0;
      cs_n     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= frame[15];
      sh       <= frame[14:0];
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else if (shifting) begin
      if (tick) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (bit_cnt == 4'd15) begin
            shifting <= 1'b0;
            holding  <= 1'b1;
            mosi     <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            mosi    <= sh[14];
            sh      <= {sh[13:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end else if (holding) begin
      if (tick) begin
        holding <= 1'b0;
        cs_n    <= 1'b1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pga_gain_driver.sv
// PGA gain driver: sends gain_ctrl changes to the PGA over SPI, then settles.
// Ports: clk, rst, gain_ctrl in; pga_cs_n/sclk/mosi, busy, gain_applied, blank out.
// Macro PGA_BLANK_EN enables the blank output; otherwise blank is tied low.
module pga_gain_driver
  import pga_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] gain_ctrl,
  output logic       pga_cs_n,
  output logic       pga_sclk,
  output logic       pga_mosi,
  output logic       busy,
  output logic [1:0] gain_applied,
  output logic       blank
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state;
  gain_t       cur_gain;
  logic        force_q;
  logic [15:0] settle_cnt;
  logic        start;
  logic        last_fall;
  logic        done;
  logic        want;
  logic        settle_term;
  logic [15:0] frame;

  assign want        = force_q || (gain_ctrl != gain_applied);
  assign settle_term = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  assign start       = (state == ST_LOAD);
  // Built straight from gain_ctrl so the frame matches the code latched in LOAD
  assign frame       = {PGA_WR_GAIN, pga_code(gain_ctrl)};

  pga_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .frame    (frame),
    .cs_n     (pga_cs_n),
    .sclk     (pga_sclk),
    .mosi     (pga_mosi),
    .last_fall(last_fall),
    .done     (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur_gain     <= '0;
      force_q      <= 1'b1;
      settle_cnt   <= '0;
      busy         <= 1'b0;
      gain_applied <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (want) state <= ST_LOAD;
        end
        ST_LOAD: begin
          cur_gain <= gain_ctrl;
          force_q  <= 1'b0;
          busy     <= 1'b1;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (last_fall) state <= ST_CS_HOLD;
        end
        ST_CS_HOLD: begin
          if (done) begin
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_term) begin
            gain_applied <= cur_gain;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PGA_BLANK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank <= 1'b1;
    end else if (state == ST_IDLE && want) begin
      blank <= 1'b1;
    end else if (settle_term) begin
      blank <= 1'b0;
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: doc/pga_gain_driver.md
PGA_GAIN_DRIVER -- requirements
Module: pga_gain_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 Parameter SETTLE_CYCLES, default 1000: post-write analog settle time in clk cycles, legal range 1..65535.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 gain_ctrl  input  2  requested gain code from auto_gain_control, sampled every clk.
REQ-006 pga_cs_n  output  1  PGA SPI chip select, active low.
REQ-007 pga_sclk  output  1  PGA SPI clock, mode 0, idle low.
REQ-008 pga_mosi  output  1  PGA SPI data, MSB first.
REQ-009 busy  output  1  high from frame start until settle completes.
REQ-010 gain_applied  output  2  gain code currently valid at the PGA.
REQ-011 blank  output  1  high while ADC samples are invalid because of a gain change.

Function
REQ-012 States: IDLE, LOAD, SHIFT, CS_HOLD, SETTLE; encoding is implementation choice.
REQ-013 IDLE->LOAD when gain_ctrl != gain_applied, or when the force flag is set; the force flag is set by reset and cleared in LOAD.
REQ-014 LOAD, 1 cycle: latch gain_ctrl into cur_gain; build frame {8'h41, PGA_CODE[cur_gain]}; drive pga_cs_n=0 and pga_mosi=bit15; busy=1.
REQ-015 SHIFT: sclk rises CLK_DIV cycles after cs_n falls, then toggles every CLK_DIV cycles; pga_mosi updates on each falling edge; 16 rising edges are sent.
REQ-016 CS_HOLD: entered on the final falling edge; pga_cs_n returns to 1 after CLK_DIV cycles.
REQ-017 Frame length from cs_n fall to cs_n rise is 33*CLK_DIV clk cycles.
REQ-018 SETTLE: count SETTLE_CYCLES cycles. On terminal count: gain_applied<=cur_gain, busy<=0, go to IDLE.
REQ-019 gain_ctrl changes during LOAD..SETTLE are ignored. The current frame and settle always complete. REQ-013 then re-evaluates in IDLE, so only the latest requested value is sent.
REQ-020 If gain_ctrl returns to gain_applied before the current sequence ends, the in-flight frame still completes and gain_applied takes cur_gain. A second frame then restores the requested value.
REQ-021 PGA_CODE mapping: 0->8'h00 (x1), 1->8'h01 (x2), 2->8'h03 (x4), 3->8'h07 (x8).
REQ-022 The bit counter is 4 bits; the divider counter is 8 bits; the settle counter is 16 bits. All counters are unsigned and never wrap within a frame.
REQ-023 Outputs are registered; no combinational path from gain_ctrl to any output.

Reset
REQ-024 On rst: state=IDLE, pga_cs_n=1, pga_sclk=0, pga_mosi=0, busy=0, blank=1, gain_applied=0, force flag=1.
REQ-025 Reset asserted mid-frame aborts the frame immediately: cs_n goes high with no further sclk edges. After release, a forced gain-0 frame is sent first.

Configuration
REQ-026 Macro PGA_BLANK_EN.
REQ-027 Defined: blank=1 from LOAD through the SETTLE terminal cycle, and also after reset until the first settle completes; otherwise blank=0.
REQ-028 Undefined: blank is tied to 0, and only busy indicates the transition.

Structure
REQ-029 Package pga_pkg holds the following, and pga_gain_driver imports it:
- gain_t (2-bit type)
- the PGA_CODE lookup function or constant array
- the opcode constant PGA_WR_GAIN=8'h41
- the state enum type
REQ-030 One sub-module, pga_spi_shifter (16-bit mode-0 serializer with start/done), is natural. The FSM and settle counter stay in the top level.

Verification
REQ-031 Release rst with gain_ctrl=0 -> one frame 16'h4100; 33*4 cycles cs_n low; busy falls SETTLE_CYCLES later; gain_applied=0; blank falls with busy.
REQ-032 gain_ctrl 0->2 while idle -> frame 16'h4103 starts 2 cycles after the change; gain_applied=2 only after settle.
REQ-033 gain_ctrl 1->3 then 3->2 mid-SHIFT -> frame 16'h4107 completes, gain_applied=3, then a second frame 16'h4103 follows and gain_applied=2.
REQ-034 gain_ctrl 0->1->0 within one frame -> frame 16'h4101 is sent, gain_applied=1, then frame 16'h4100 and gain_applied=0.
REQ-035 rst pulse after bit 7 -> cs_n=1 and sclk=0 within the reset cycle, no partial-frame edges after it; the next frame is 16'h4100.
REQ-036 Build without PGA_BLANK_EN and repeat REQ-032 -> blank stays 0 throughout; busy behaviour is identical.
